// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    localparam int unsigned DM_DEFAULT_DEPTH = 3072;
    localparam int unsigned DM_DATA_W        = 32;
    localparam int unsigned DM_BE_W          = DM_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam logic [DM_BE_W-1:0] BE_WORD    = 4'b1111;
    localparam logic [DM_BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [DM_BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [DM_BE_W-1:0] BE_B0      = 4'b0001;
    localparam logic [DM_BE_W-1:0] BE_B1      = 4'b0010;
    localparam logic [DM_BE_W-1:0] BE_B2      = 4'b0100;
    localparam logic [DM_BE_W-1:0] BE_B3      = 4'b1000;

    // Request payload captured at acceptance (address index kept separately).
    typedef struct packed {
        logic                 we;
        logic [DM_BE_W-1:0]   be;
        logic [DM_DATA_W-1:0] wdata;
        logic [DM_DATA_W-1:0] pc;
    } dm_req_t;

    // Expand byte enables into a per-bit data mask.
    function automatic logic [DM_DATA_W-1:0] be_mask(input logic [DM_BE_W-1:0] be);
        logic [DM_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(DM_BE_W); b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response handshake bundle between the memory stage and the responder.
interface dm_responder_if
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [DM_BE_W-1:0]   req_be;
    logic [DM_DATA_W-1:0] req_wdata;
    logic [DM_DATA_W-1:0] req_pc;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DM_DATA_W-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_word_array.sv
// Word-organised data store with byte-enable write, combinational read and range check.
module dm_word_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEFAULT_DEPTH,
    parameter int unsigned IDX_W = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [DM_BE_W-1:0]   be_i,
    input  logic [DM_DATA_W-1:0] wdata_i,
    output logic [DM_DATA_W-1:0] rdata_c,
    output logic                 in_range_c
);

    localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DM_DATA_W-1:0] mem_q [DEPTH];
    logic [ROW_W-1:0]     row;

    // Full index is compared so aliased high bits never hit a real row.
    assign in_range_c = (idx_i < IDX_W'(DEPTH));
    assign row        = idx_i[ROW_W-1:0];
    assign rdata_c    = in_range_c ? mem_q[row] : '0;

    // Storage: cleared on reset, byte-merged on an in-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && in_range_c) begin
            for (int b = 0; b < int'(DM_BE_W); b++) begin
                if (be_i[b]) begin
                    mem_q[row][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accept, wait LATENCY cycles, access, respond.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH   = DM_DEFAULT_DEPTH,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    dm_responder_if.slave bus
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    dm_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    dm_req_t               req_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [DM_DATA_W-1:0]  rdata_q;
    logic                  err_q;

    logic                  accept_c;
    logic                  do_access_c;
    dm_req_t               acc_c;
    logic [IDX_W-1:0]      acc_idx_c;
    logic [DM_DATA_W-1:0]  rd_c;
    logic                  in_range_c;
    logic                  wr_en_c;
    logic [DM_DATA_W-1:0]  merged_c;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // Next-state, counter and access-strobe decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_c    = 1'b0;
        do_access_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept_c = 1'b1;
                    if (LATENCY == 0) begin
                        do_access_c = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    do_access_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Access operands: live inputs for a zero-latency access in IDLE, latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_c.we    = bus.req_we;
            acc_c.be    = bus.req_be;
            acc_c.wdata = bus.req_wdata;
            acc_c.pc    = bus.req_pc;
            acc_idx_c   = bus.req_addr[ADDR_W-1:2];
        end else begin
            acc_c     = req_q;
            acc_idx_c = idx_q;
        end
    end

    assign wr_en_c  = do_access_c && acc_c.we && (acc_c.be != '0);
    assign merged_c = (rd_c & ~be_mask(acc_c.be)) | (acc_c.wdata & be_mask(acc_c.be));

    dm_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (wr_en_c),
        .idx_i      (acc_idx_c),
        .be_i       (acc_c.be),
        .wdata_i    (acc_c.wdata),
        .rdata_c    (rd_c),
        .in_range_c (in_range_c)
    );

    // State, counter, request latch and registered handshake/response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            idx_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            if (accept_c) begin
                req_q.we    <= bus.req_we;
                req_q.be    <= bus.req_be;
                req_q.wdata <= bus.req_wdata;
                req_q.pc    <= bus.req_pc;
                idx_q       <= bus.req_addr[ADDR_W-1:2];
            end
            if (do_access_c) begin
                rdata_q <= (!acc_c.we && in_range_c) ? rd_c : '0;
                err_q   <= !in_range_c;
            end
        end
    end

    // Store trace, one line per committed store that actually changes bytes.
    always_ff @(posedge clk) begin
        if (reset && wr_en_c && in_range_c) begin
            $display("%d@%h: *%h <= %h", $time, acc_c.pc, {acc_idx_c, 2'b00}, merged_c);
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
